// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, round-robin
// grant among full slots, registered broadcast of the winning result.
module cdb_arbiter #(
  parameter int N_SOURCES = 4,
  parameter int RSV_ID_W  = 4,
  parameter int DATA_W    = 32,
  parameter int SRC_W     = $clog2(N_SOURCES),
  parameter int CDB_W     = RSV_ID_W + DATA_W
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       flush,
  input  logic [N_SOURCES-1:0]       s_valid,
  input  logic [N_SOURCES*CDB_W-1:0] s_data,
  output logic [N_SOURCES-1:0]       s_ready,
  output logic                       cdb_valid,
  output logic [CDB_W-1:0]           cdb,
  output logic [SRC_W-1:0]           cdb_src
);

  logic [N_SOURCES-1:0] slot_full_q, slot_full_d;
  logic [CDB_W-1:0]     slot_data_q [N_SOURCES];
  logic [CDB_W-1:0]     slot_data_d [N_SOURCES];
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [CDB_W-1:0]     cdb_q, cdb_d;
  logic [SRC_W-1:0]     cdb_src_q, cdb_src_d;

  logic [N_SOURCES-1:0] grant;
  logic [N_SOURCES-1:0] accept;
  logic                 grant_any;
  logic [SRC_W-1:0]     winner;
  int unsigned          scan_idx;

  // Winner is the first full slot at or after rr_ptr, wrapping modulo N_SOURCES.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    winner    = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < N_SOURCES; k++) begin
      scan_idx = (32'(rr_ptr_q) + k) % N_SOURCES;
      if (!grant_any && slot_full_q[SRC_W'(scan_idx)]) begin
        grant_any = 1'b1;
        winner    = SRC_W'(scan_idx);
      end
    end
    if (grant_any) grant[winner] = 1'b1;
  end

  assign s_ready = ~slot_full_q | grant;
  assign accept  = s_valid & s_ready;

  always_comb begin
    slot_full_d = slot_full_q;
    slot_data_d = slot_data_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_d       = cdb_q;
    cdb_src_d   = cdb_src_q;
    if (flush) begin
      slot_full_d = '0;
      rr_ptr_d    = '0;
    end else begin
      // Accept wins over grant so a granted slot can refill in the same cycle.
      for (int unsigned i = 0; i < N_SOURCES; i++) begin
        if (accept[i]) begin
          slot_full_d[i] = 1'b1;
          slot_data_d[i] = s_data[i*CDB_W +: CDB_W];
        end else if (grant[i]) begin
          slot_full_d[i] = 1'b0;
        end
      end
      cdb_valid_d = grant_any;
      if (grant_any) begin
        cdb_d     = slot_data_q[winner];
        cdb_src_d = winner;
        rr_ptr_d  = (winner == SRC_W'(N_SOURCES - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      slot_full_q <= '0;
      slot_data_q <= '{default: '0};
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
      cdb_src_q   <= '0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_data_q <= slot_data_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_q       <= cdb_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb       = cdb_q;
  assign cdb_src   = cdb_src_q;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!nrst) $onehot0(grant));
  a_ready_full    : assert property (@(posedge clk) disable iff (!nrst)
                                     (~s_ready & ~slot_full_q) == '0);
  a_valid_granted : assert property (@(posedge clk) disable iff (!nrst)
                                     cdb_valid_q |-> $past($onehot(grant)));

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sits directly downstream of the functional units that are fed by reservation_station instances.
- Collects one completed result per source, arbitrates round-robin among pending results, and drives the single common data bus (cdb_valid, cdb).
- The cdb output is broadcast back to every reservation station and to the ROB.
- Each source has a one-entry holding slot, so a functional unit can retire a result while it waits for a bus grant.

Parameters:
N_SOURCES, 4, number of result producers (functional units) competing for the CDB; must be ≥ 2.
SRC_W, $clog2(N_SOURCES), width of the round-robin pointer and grant index.

Ports:
clk  input  1  clock; all state updates on the rising edge.
nrst  input  1  asynchronous active-low reset.
flush  input  1  synchronous squash; discards all pending and outgoing results.
s_valid  input  N_SOURCES  per-source result valid.
s_data  input  N_SOURCES*CDB_W  per-source result; source i occupies bits [i*CDB_W +: CDB_W].
s_ready  output  N_SOURCES  per-source slot can accept.
cdb_valid  output  1  registered broadcast valid.
cdb  output  CDB_W  registered broadcast; CDB_W = RSV_ID_W + DATA_W.
cdb_src  output  SRC_W  index of the source that produced the current cdb word (debug/perf).

Behaviour:
- Reset (nrst low, asynchronous):
  - all slots empty; rr_ptr = 0.
  - cdb_valid = 0, cdb = 0, cdb_src = 0.
  - s_ready is all ones combinationally from the empty slots.
- CDB word format: tag = cdb[DATA_W +: RSV_ID_W]; value = cdb[0 +: DATA_W]. The block passes s_data through bit-exact; it never inspects or alters fields.
- Slot state per source i: slot_full[i], slot_data[i].
- Grant, combinational from registered state only:
  - Winner is the first full slot found scanning i = rr_ptr, rr_ptr+1, … modulo N_SOURCES.
  - grant[i] is one-hot; it is all zero when no slot is full.
- s_ready[i] = !slot_full[i] | grant[i]. It does not depend on s_valid.
- Slot update each edge, unless flush or reset:
  - accept (s_valid[i] & s_ready[i]): slot_full[i] <= 1 and slot_data[i] <= s_data[i]. This covers the same-cycle grant-and-refill case, where the slot stays full with the new data.
  - granted without accept: slot_full[i] <= 0.
  - otherwise: hold.
- CDB register each edge:
  - cdb_valid <= |grant.
  - when a grant exists, cdb <= winner's slot_data and cdb_src <= winner index.
  - when no grant exists, cdb and cdb_src hold their previous values; only cdb_valid drops.
- Pointer: when a grant exists, rr_ptr <= winner+1 mod N_SOURCES; otherwise rr_ptr holds.
- Latency: a result accepted at edge N appears on cdb at edge N+1 at the earliest (no contention).
- Sustained throughput is one broadcast per cycle. A single source issuing back-to-back gets one broadcast per cycle with no bubbles.
- Fairness: with all N_SOURCES slots continuously full, each source is granted exactly once in every N_SOURCES consecutive cycles. Worst-case wait is N_SOURCES−1 cycles after the slot fills.
- There is no downstream backpressure. The CDB is a broadcast, and consumers must sample every cycle cdb_valid is high.
- flush (synchronous, higher priority than accept/grant):
  - at the edge: all slots empty, cdb_valid <= 0, rr_ptr <= 0.
  - s_valid offered in the flush cycle is dropped even though s_ready is high.
- Asserting reset mid-operation immediately clears all slots and cdb_valid, without waiting for a clock edge. The results in flight are lost by design.
- Assertions:
  - cdb_valid implies that exactly one slot was granted in the previous cycle.
  - grant is $onehot0.
  - s_ready[i] = 0 only when slot_full[i] = 1.

Test Plan:
1. Single source: reset; s_valid[2]=1 with tag 5, value 0xDEADBEEF for one cycle. Required: cdb_valid=1 exactly one cycle later, with cdb tag 5, value 0xDEADBEEF and cdb_src=2; then cdb_valid=0.
2. Full contention: all 4 sources hold s_valid=1 continuously, with source i sending value 0x100+i. Required: cdb_src sequence is 0,1,2,3,0,1,…; cdb_valid stays high every cycle; each s_ready[i] goes high once per 4 cycles.
3. Back-to-back single source: source 1 streams values 1..8 on consecutive cycles. Required: cdb shows 1..8 on 8 consecutive cycles, cdb_src=1, and s_ready[1] never drops.
4. Blocked source: sources 0 and 3 become valid together with rr_ptr=0. Required:
   - source 0 broadcasts first and source 3 second.
   - s_ready[3] is low for exactly 1 cycle.
   - source 3's data is held unchanged while s_valid[3] remains asserted with new data ignored.
5. Flush: fill slots 0–2 and assert flush for one cycle. Required: cdb_valid=0 the following cycle; none of the three results is ever broadcast; rr_ptr returns to 0, so the next single request from source 2 broadcasts with 1-cycle latency.
6. Async reset mid-stream: during scenario 2, pull nrst low between clock edges. Required: cdb_valid=0 and s_ready=4'b1111 before the next rising edge. After release, the first grant goes to source 0.
